// File: rtl/note_stream_seq_if.sv
// ---------------------------------------------------------------------------
// note_stream_seq_if
//   Byte stream from the note streamer to the UART transmitter.
//   Each byte is held on tx_data while tx_valid is high and is consumed in a
//   cycle where tx_valid and tx_ready are both high.
//
//   tx_data   8  ASCII byte              (master -> slave)
//   tx_valid  1  byte available          (master -> slave)
//   tx_ready  1  slave accepts the byte  (slave  -> master)
// ---------------------------------------------------------------------------
interface note_stream_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface : note_stream_seq_if

// File: rtl/note_stream_seq.sv
// ---------------------------------------------------------------------------
// note_stream_seq
//   Plays one of SONGS runtime-loadable note tables as ASCII byte pairs
//   (tile letter 'A'+tile, then duration digit '0'+dur, or 'X' for dur 0)
//   over a valid/ready byte stream. Supports start/stop, looping, per-song
//   lengths, a done pulse, and stopping only at note boundaries.
//
//   Build option: define NOTE_STREAM_DELIM_EN to append a LF (8'h0A) byte
//   after every note (3 bytes per note instead of 2).
//
//   Ports
//     clk, rst              clock (rising edge), async active-high reset
//     start, stop           one-cycle play / stop requests
//     loop_en               replay from note 0 at end of table
//     song_sel              table to play, sampled with start
//     wr_en/wr_song/
//     wr_addr/wr_data       note-table write port ({tile, dur})
//     len_we/len_data       length write for table wr_song (saturates at DEPTH)
//     tx                    byte stream (note_stream_seq_if.master)
//     busy                  playback active
//     done                  one-cycle pulse: table finished without loop
//     note_idx              index of the note being sent
// ---------------------------------------------------------------------------
module note_stream_seq #(
  parameter int SONGS  = 2,
  parameter int DEPTH  = 64,
  parameter int TILE_W = 4,
  parameter int DUR_W  = 3,
  parameter int SONG_W = 1,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [SONG_W-1:0]        song_sel,
  input  logic                     wr_en,
  input  logic [SONG_W-1:0]        wr_song,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [TILE_W+DUR_W-1:0]  wr_data,
  input  logic                     len_we,
  input  logic [ADDR_W:0]          len_data,
  note_stream_seq_if.master        tx,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        note_idx
);

  localparam int ENT_W = TILE_W + DUR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef NOTE_STREAM_DELIM_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  logic [ENT_W-1:0]  mem_q [SONGS*DEPTH];
  logic [ENT_W-1:0]  rd_q;
  logic [ADDR_W:0]   len_q [SONGS];

  logic [1:0]        state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   act_len_q, act_len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        byte1_q, byte1_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;

  logic              wr_ok, sel_ok, last_note, stop_now;
  logic [TILE_W-1:0] tile;
  logic [DUR_W-1:0]  dur;

  // Out-of-range song numbers (only possible when SONGS < 2**SONG_W) are ignored.
  assign wr_ok     = int'(wr_song)  < SONGS;
  assign sel_ok    = int'(song_sel) < SONGS;
  assign tile      = rd_q[ENT_W-1:DUR_W];
  assign dur       = rd_q[DUR_W-1:0];
  assign last_note = ({1'b0, idx_q} == act_len_q - (ADDR_W+1)'(1));
  // A stop arriving together with the final handshake still counts.
  assign stop_now  = stop_pend_q | stop;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    act_len_d   = act_len_q;
    byte_idx_d  = byte_idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    byte1_d     = byte1_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    if (state_q != S_IDLE && stop) stop_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && sel_ok) begin
          if (len_q[song_sel] != '0) begin
            song_d    = song_sel;
            act_len_d = len_q[song_sel];
            idx_d     = '0;
            state_d   = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;   // RAM address {song_q, idx_q} is read this cycle
      S_LOAD: begin
        tx_data_d  = 8'h41 + 8'(tile);
        byte1_d    = (dur == '0) ? 8'h58 : 8'h30 + 8'(dur);
        byte_idx_d = 2'd0;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && tx.tx_ready) begin
          if (byte_idx_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            if (stop_now) begin
              state_d = S_IDLE;
            end else if (last_note && loop_en) begin
              idx_d   = '0;
              state_d = S_FETCH;
            end else if (last_note) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
`ifdef NOTE_STREAM_DELIM_EN
            tx_data_d  = (byte_idx_q == 2'd0) ? byte1_q : 8'h0A;
`else
            tx_data_d  = byte1_q;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_pend_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      song_q      <= '0;
      idx_q       <= '0;
      act_len_q   <= '0;
      byte_idx_q  <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      byte1_q     <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      for (int s = 0; s < SONGS; s++) len_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      act_len_q   <= act_len_d;
      byte_idx_q  <= byte_idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      byte1_q     <= byte1_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      // Length writes never touch act_len_q, so the playing song keeps its
      // snapshot.
      if (len_we && wr_ok) len_q[wr_song] <= (len_data > DEPTH_L) ? DEPTH_L : len_data;
    end
  end

  // NOTE: the note RAM has no reset so it maps onto block RAM; its contents
  // survive rst and only the length registers return to zero.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem_q[{wr_song, wr_addr}] <= wr_data;
    rd_q <= mem_q[{song_q, idx_q}];
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign note_idx    = idx_q;

endmodule : note_stream_seq

// File: tb/tb_note_stream_seq.sv
// ---------------------------------------------------------------------------
// tb_note_stream_seq
//   Self-checking bench for note_stream_seq. A transaction-level model keeps
//   the note tables and predicts the byte stream (with note indices), the
//   busy window and the done pulse; a negedge process compares the DUT
//   against it every cycle. Directed scenarios pin the model with literal
//   byte sequences and latencies, then randomized playback follows.
// ---------------------------------------------------------------------------
module tb_note_stream_seq;
  localparam int SONGS = 2, DEPTH = 64, TILE_W = 4, DUR_W = 3, SONG_W = 1, ADDR_W = 6;
`ifdef NOTE_STREAM_DELIM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [SONG_W-1:0]       song_sel = '0;
  logic                    wr_en = 1'b0, len_we = 1'b0;
  logic [SONG_W-1:0]       wr_song = '0;
  logic [ADDR_W-1:0]       wr_addr = '0;
  logic [TILE_W+DUR_W-1:0] wr_data = '0;
  logic [ADDR_W:0]         len_data = '0;
  logic                    busy, done;
  logic [ADDR_W-1:0]       note_idx;

  note_stream_seq_if bif ();

  note_stream_seq #(.SONGS(SONGS), .DEPTH(DEPTH), .TILE_W(TILE_W), .DUR_W(DUR_W),
                    .SONG_W(SONG_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .song_sel(song_sel), .wr_en(wr_en), .wr_song(wr_song), .wr_addr(wr_addr),
    .wr_data(wr_data), .len_we(len_we), .len_data(len_data), .tx(bif),
    .busy(busy), .done(done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] b;
    int         idx;
    int         tag;
  } exp_t;

  logic [TILE_W+DUR_W-1:0] mem_m [SONGS][DEPTH];
  int   len_m [SONGS];
  exp_t exp_q [$];
  logic [7:0] got_q [$];
  int   act_song, act_len, tag_ctr = 0, done_seen = 0;
  bit   playing = 0, exp_done = 0, stopped = 0, prev_stall = 0;
  logic [7:0] prev_data;

  function automatic void push_note(input int song, input int idx);
    logic [TILE_W+DUR_W-1:0] e;
    exp_t x;
    e     = mem_m[song][idx];
    x.idx = idx;
    x.tag = tag_ctr;
    x.b   = 8'h41 + 8'(e[TILE_W+DUR_W-1:DUR_W]);
    exp_q.push_back(x);
    x.b   = (e[DUR_W-1:0] == 0) ? 8'h58 : 8'h30 + 8'(e[DUR_W-1:0]);
    exp_q.push_back(x);
    if (NB == 3) begin
      x.b = 8'h0A;
      exp_q.push_back(x);
    end
    tag_ctr++;
  endfunction

  function automatic void push_pass();
    for (int i = 0; i < act_len; i++) push_note(act_song, i);
  endfunction

  // Compare, then advance the model with the inputs the next edge samples.
  always @(negedge clk) begin : compare
    exp_t x;
    bit play_n, done_n;
    if (rst) begin
      exp_q.delete();
      playing = 0; exp_done = 0; stopped = 0; prev_stall = 0;
      for (int s = 0; s < SONGS; s++) len_m[s] = 0;
    end else begin
      check("busy", busy, playing);
      check("done", done, exp_done);
      if (!playing) check("idle_valid", bif.tx_valid, 0);
      if (prev_stall) begin
        check("stall_valid", bif.tx_valid, 1);
        check("stall_data", bif.tx_data, prev_data);
      end
      if (done) done_seen++;

      play_n = playing;
      done_n = 0;
      if (!playing) begin
        if (start) begin
          if (len_m[song_sel] != 0) begin
            act_song = int'(song_sel);
            act_len  = len_m[song_sel];
            exp_q.delete();
            stopped = 0;
            push_pass();
            play_n = 1;
          end else begin
            done_n = 1;
          end
        end
      end else begin
        // Stop keeps only the note already in flight.
        if (stop && exp_q.size() > 0) begin
          while (exp_q[$].tag != exp_q[0].tag) void'(exp_q.pop_back());
          stopped = 1;
        end
        if (bif.tx_valid && bif.tx_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", bif.tx_data, 0);
          end else begin
            x = exp_q.pop_front();
            check("tx_data", bif.tx_data, x.b);
            check("note_idx", note_idx, x.idx);
            got_q.push_back(bif.tx_data);
            if (exp_q.size() == 0) begin
              if (!stopped && loop_en) push_pass();
              else begin
                play_n = 0;
                done_n = !stopped;
              end
            end
          end
        end
      end
      if (wr_en)  mem_m[wr_song][wr_addr] = wr_data;
      if (len_we) len_m[wr_song] = (int'(len_data) > DEPTH) ? DEPTH : int'(len_data);

      prev_stall = bif.tx_valid && !bif.tx_ready;
      prev_data  = bif.tx_data;
      playing    = play_n;
      exp_done   = done_n;
    end
  end

  // ---------------- tx_ready driver ----------------
  int rdy_mode = 0;   // 0 always, 1 one-in-three, 2 random, 3 held low
  int rdy_cnt  = 0;
  initial begin
    bif.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bif.tx_ready = 1'b1;
        1:       bif.tx_ready = (rdy_cnt % 3 == 0);
        2:       bif.tx_ready = 1'($urandom_range(0, 1));
        default: bif.tx_ready = 1'b0;
      endcase
      rdy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_note(input int s, input int a, input logic [TILE_W+DUR_W-1:0] d);
    wr_en = 1; wr_song = SONG_W'(s); wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic wr_len(input int s, input int l);
    len_we = 1; wr_song = SONG_W'(s); len_data = (ADDR_W+1)'(l);
    tick();
    len_we = 0;
  endtask

  task automatic pulse_start(input int s);
    start = 1; song_sel = SONG_W'(s);
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
    tick(); tick();
  endtask

  logic [7:0] song0_exp [$];

  task automatic check_song0(input string name);
    check({name, "_len"}, got_q.size(), song0_exp.size());
    for (int i = 0; i < song0_exp.size() && i < got_q.size(); i++)
      check(name, got_q[i], song0_exp[i]);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin : main
    int n, l, s;
    song0_exp = {8'h41, 8'h32};
`ifdef NOTE_STREAM_DELIM_EN
    song0_exp.push_back(8'h0A);
`endif
    song0_exp.push_back(8'h4D);
    song0_exp.push_back(8'h34);
`ifdef NOTE_STREAM_DELIM_EN
    song0_exp.push_back(8'h0A);
`endif

    #2;
    check("rst_tx_valid", bif.tx_valid, 0);
    check("rst_tx_data", bif.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_note_idx", note_idx, 0);
    tick(); tick();
    rst = 0;
    tick();

    // Fill every entry so no table read ever returns unwritten data.
    for (int ss = 0; ss < SONGS; ss++)
      for (int a = 0; a < DEPTH; a++)
        wr_note(ss, a, (TILE_W+DUR_W)'($urandom));

    // Scenario 1: A2M4 with ready held high, exact latencies.
    wr_note(0, 0, {4'd0, 3'b010});
    wr_note(0, 1, {4'd12, 3'b100});
    wr_len(0, 2);
    got_q.delete(); done_seen = 0; rdy_mode = 0;
    pulse_start(0);
    check("lat_busy_n1", busy, 1);
    check("lat_valid_n1", bif.tx_valid, 0);
    tick();
    check("lat_valid_n2", bif.tx_valid, 0);
    tick();
    check("lat_valid_n3", bif.tx_valid, 1);
    check("lat_data_n3", bif.tx_data, 8'h41);
    wait_idle(100);
    check_song0("s1_bytes");
    check("s1_done_cycles", done_seen, 1);

    // Scenario 2: same table with 1-in-3 ready.
    got_q.delete(); done_seen = 0; rdy_mode = 1;
    pulse_start(0);
    wait_idle(200);
    check_song0("s2_bytes");
    check("s2_done_cycles", done_seen, 1);

    // Scenario 3: looping "DX", stop during the second X.
    wr_note(1, 0, {4'd3, 3'b000});
    wr_len(1, 1);
    got_q.delete(); done_seen = 0; rdy_mode = 0; loop_en = 1;
    pulse_start(1);
    n = 0;
    while (!(bif.tx_valid && bif.tx_data == 8'h58 && got_q.size() >= 3) && n < 200) begin
      tick();
      n++;
    end
    check("s3_reach_x", n < 200, 1);
    stop = 1;
    tick();
    stop = 0;
    wait_idle(100);
    loop_en = 0;
    check("s3_count", got_q.size(), 2 * NB);
    for (int i = 0; i < got_q.size(); i++)
      check("s3_bytes", got_q[i], (i % NB == 0) ? 8'h44 : (i % NB == 1) ? 8'h58 : 8'h0A);
    check("s3_no_done", done_seen, 0);

    // Scenario 4: zero-length table.
    wr_len(0, 0);
    pulse_start(0);
    check("s4_done", done, 1);
    check("s4_busy", busy, 0);
    tick();
    check("s4_done_gone", done, 0);

    // Scenario 5: async reset while a byte is stalled.
    wr_len(0, 2);
    rdy_mode = 3;
    pulse_start(0);
    n = 0;
    while (!bif.tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("s5_pre_valid", bif.tx_valid, 1);
    #2 rst = 1;
    #1;
    check("s5_async_valid", bif.tx_valid, 0);
    check("s5_async_busy", busy, 0);
    check("s5_async_idx", note_idx, 0);
    tick(); tick();
    rst = 0; rdy_mode = 0;
    tick();
    pulse_start(0);
    check("s5_len_reset_done", done, 1);
    wr_len(0, 2);
    got_q.delete(); done_seen = 0;
    pulse_start(0);
    wait_idle(100);
    check_song0("s5_replay");

    // Randomized playback.
    for (int it = 0; it < 30; it++) begin
      s = $urandom_range(0, SONGS - 1);
      for (int k = 0; k < 4; k++)
        wr_note(s, $urandom_range(0, 9), (TILE_W+DUR_W)'($urandom));
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 2 * DEPTH - 1) : $urandom_range(0, 8);
      wr_len(s, l);
      rdy_mode = $urandom_range(0, 2);
      loop_en  = ($urandom_range(0, 3) == 0);
      pulse_start(s);
      for (int c = 0; c < 400 && busy; c++) begin
        stop     = ($urandom_range(0, 49) == 0) || (c > 300);
        start    = ($urandom_range(0, 29) == 0);
        song_sel = SONG_W'($urandom_range(0, SONGS - 1));
        len_we   = ($urandom_range(0, 19) == 0);
        wr_song  = SONG_W'($urandom_range(0, SONGS - 1));
        len_data = (ADDR_W+1)'($urandom_range(0, 8));
        tick();
      end
      stop = 0; start = 0; len_we = 0;
      wait_idle(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_note_stream_seq
